// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving a combinational 4-bit ALU
// Owns the register file, ALU operand/select registers and the READ result channel.
module alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [2:0]               instr_op,
  input  logic [$clog2(NREG)-1:0]  instr_rd,
  input  logic [$clog2(NREG)-1:0]  instr_ra,
  input  logic [$clog2(NREG)-1:0]  instr_rb,
  input  logic [WIDTH-1:0]         instr_imm,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_s2,
  output logic                     alu_s1,
  output logic                     alu_s0,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     res_valid,
  output logic [WIDTH-1:0]         res_data,
  input  logic                     res_ready,
  output logic                     zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_READ = 3'b111;

  state_t                    r_state;
  logic [2:0]                r_op;
  logic [$clog2(NREG)-1:0]   r_rd;
  logic [$clog2(NREG)-1:0]   r_ra;
  logic [WIDTH-1:0]          r_imm;
  logic [WIDTH-1:0]          r_alu_a;
  logic [WIDTH-1:0]          r_alu_b;
  logic [2:0]                r_sel;
  logic                      r_res_valid;
  logic [WIDTH-1:0]          r_res_data;
  logic                      r_zero;
  logic [WIDTH-1:0]          r_regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_rd        <= '0;
      r_ra        <= '0;
      r_imm       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_sel       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_zero      <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op    <= instr_op;
            r_rd    <= instr_rd;
            r_ra    <= instr_ra;
            r_imm   <= instr_imm;
            r_alu_a <= r_regs[instr_ra];
            r_alu_b <= r_regs[instr_rb];
            // LOAD and READ park the ALU select lines on AND
            r_sel   <= (instr_op[2:1] == 2'b11) ? 3'b000 : instr_op;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (r_op)
            OP_LOAD: begin
              r_regs[r_rd] <= r_imm;
              r_zero       <= (r_imm == '0);
              r_state      <= S_IDLE;
            end
            OP_READ: begin
              r_res_data  <= r_regs[r_ra];
              r_res_valid <= 1'b1;
              r_state     <= S_RESP;
            end
            default: begin
              r_regs[r_rd] <= alu_out;
              r_zero       <= (alu_out == '0);
              r_state      <= S_IDLE;
            end
          endcase
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_s2      = r_sel[2];
  assign alu_s1      = r_sel[1];
  assign alu_s0      = r_sel[0];
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign zero        = r_zero;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
// Provides a behavioural ALU and a register-file reference model.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_ra, instr_rb;
  logic [3:0] instr_imm;
  logic [3:0] alu_a, alu_b, alu_out;
  logic       alu_s2, alu_s1, alu_s0;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_ready;
  logic       zero;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(4), .NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_ra(instr_ra), .instr_rb(instr_rb), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s2(alu_s2), .alu_s1(alu_s1), .alu_s0(alu_s0),
    .alu_out(alu_out), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .zero(zero)
  );

  // The external combinational ALU
  always_comb begin
    alu_out = 4'd0;
    case ({alu_s2, alu_s1, alu_s0})
      3'd0: alu_out = alu_a & alu_b;
      3'd1: alu_out = alu_a | alu_b;
      3'd2: alu_out = alu_a ^ alu_b;
      3'd3: alu_out = ~alu_a;
      3'd4: alu_out = alu_a - alu_b;
      3'd5: alu_out = alu_a + alu_b;
      default: alu_out = 4'd0;
    endcase
  end

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] m_r [4];
  logic       m_zero;
  int         acc_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_alu(input int op, input int a, input int b);
    case (op)
      0: return 4'(a & b);
      1: return 4'(a | b);
      2: return 4'(a ^ b);
      3: return 4'(15 - a);
      4: return 4'((a - b + 16) % 16);
      5: return 4'((a + b) % 16);
      default: return 4'd0;
    endcase
  endfunction

  // Offer an instruction from a negedge; returns at the negedge inside EXEC
  task automatic issue(input int op, input int rd, input int ra, input int rb, input int imm);
    int n;
    instr_op    = 3'(op);
    instr_rd    = 2'(rd);
    instr_ra    = 2'(ra);
    instr_rb    = 2'(rb);
    instr_imm   = 4'(imm);
    instr_valid = 1'b1;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) check("accept_timeout", 32'(instr_ready), 1);
    @(posedge clk);
    acc_t = int'($time / 10);
    @(negedge clk);
  endtask

  task automatic read_resp(input logic [3:0] exp, input int delay);
    int n;
    res_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("res_valid", 32'(res_valid), 1);
    check("res_data", 32'(res_data), 32'(exp));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(res_valid), 1);
      check("hold_data", 32'(res_data), 32'(exp));
      check("hold_ready", 32'(instr_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_clr", 32'(res_valid), 0);
  endtask

  task automatic do_instr(input int op, input int rd, input int ra, input int rb,
                          input int imm, input int delay);
    logic [3:0] e;
    issue(op, rd, ra, rb, imm);
    instr_valid = 1'b0;
    check("sel", 32'({alu_s2, alu_s1, alu_s0}), (op < 6) ? op : 0);
    check("alu_a", 32'(alu_a), 32'(m_r[ra]));
    check("alu_b", 32'(alu_b), 32'(m_r[rb]));
    if (op < 6) begin
      e = ref_alu(op, int'(m_r[ra]), int'(m_r[rb]));
      m_r[rd] = e;
      m_zero  = (e == 4'd0);
    end else if (op == 6) begin
      m_r[rd] = 4'(imm);
      m_zero  = (imm == 0);
    end else begin
      read_resp(m_r[ra], delay);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, hs;
    rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b0;
    instr_op = '0; instr_rd = '0; instr_ra = '0; instr_rb = '0; instr_imm = '0;
    for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
    m_zero = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_data", 32'(res_data), 0);
    check("rst_zero", 32'(zero), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_b", 32'(alu_b), 0);
    check("rst_sel", 32'({alu_s2, alu_s1, alu_s0}), 0);
    @(negedge clk);

    do_instr(6, 0, 0, 0, 6, 0);
    do_instr(6, 1, 0, 0, 3, 0);
    do_instr(7, 0, 0, 0, 0, 0);
    do_instr(7, 0, 1, 0, 0, 0);
    check("load_zero", 32'(zero), 0);

    for (int op = 0; op < 6; op++) begin
      do_instr(op, 2, 0, 1, 0, 0);
      do_instr(7, 0, 2, 0, 0, 0);
    end

    do_instr(6, 0, 0, 0, 15, 0);
    do_instr(6, 1, 0, 0, 1, 0);
    do_instr(5, 2, 0, 1, 0, 0);
    @(negedge clk);
    check("wrap_zero", 32'(zero), 32'(m_zero));
    do_instr(4, 3, 1, 0, 0, 0);
    @(negedge clk);
    check("sub_zero", 32'(zero), 32'(m_zero));
    do_instr(7, 0, 2, 0, 0, 0);
    do_instr(7, 0, 3, 0, 0, 0);

    // READ stalled by res_ready while a LOAD is offered behind it
    issue(7, 0, 3, 0, 0);
    instr_op = 3'd6; instr_rd = 2'd2; instr_imm = 4'b1010;
    res_ready = 1'b0;
    @(negedge clk);
    check("bp_valid", 32'(res_valid), 1);
    check("bp_data", 32'(res_data), 32'(m_r[3]));
    repeat (4) begin
      @(negedge clk);
      check("bp_hold_data", 32'(res_data), 32'(m_r[3]));
      check("bp_ready", 32'(instr_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    hs = int'($time / 10);
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_clr", 32'(res_valid), 0);
    check("bp_ready_after", 32'(instr_ready), 1);
    @(posedge clk);
    t1 = int'($time / 10);
    @(negedge clk);
    instr_valid = 1'b0;
    check("bp_accept_gap", t1 - hs, 1);
    m_r[2] = 4'b1010;
    m_zero = 1'b0;
    do_instr(7, 0, 2, 0, 0, 0);

    // Dependent ADDs with instr_valid continuously high
    do_instr(6, 0, 0, 0, 1, 0);
    t0 = acc_t;
    for (int k = 0; k < 3; k++) begin
      do_instr(5, 0, 0, 0, 0, 0);
      check("b2b_gap", acc_t - t0, 2);
      t0 = acc_t;
    end
    do_instr(7, 0, 0, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      int op;
      op = int'($urandom_range(0, 7));
      do_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 3)));
      if (op != 7) @(negedge clk);
      check("rand_zero", 32'(zero), 32'(m_zero));
    end

    // Reset during EXEC of an ADD
    do_instr(6, 0, 0, 0, 5, 0);
    do_instr(6, 3, 0, 0, 0, 0);
    issue(5, 1, 0, 0, 0);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_zero", 32'(zero), 0);
    check("mid_rst_valid", 32'(res_valid), 0);
    check("mid_rst_alu_a", 32'(alu_a), 0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
    m_zero = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) do_instr(7, 0, i, 0, 0, 0);
    check("post_rst_zero", 32'(zero), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
